// File: rtl/fifo64_dpram_if.sv
// Producer/consumer bundle for fifo64_dpram: write port, first-word-fall-through
// read port, occupancy and status. The FIFO itself connects through the slave modport.
interface fifo64_dpram_if #(
  parameter int WIDTH = 8
);
  logic             flush;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             full;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [6:0]       level;
  logic             overflow;

  modport master (
    output flush, wr_data, wr_en, rd_ready,
    input  full, rd_data, rd_valid, level, overflow
  );

  modport slave (
    input  flush, wr_data, wr_en, rd_ready,
    output full, rd_data, rd_valid, level, overflow
  );
endinterface

// File: rtl/fifo64_dpram.sv
// 64-entry FIFO on a 64xWIDTH dual-port RAM, drained through the asynchronous
// read port into a registered valid/ready output stage (65 words total).
module fifo64_dpram #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  fifo64_dpram_if.slave  bus
);

  logic [WIDTH-1:0] mem [64];
  logic [6:0]       wr_ptr, rd_ptr;
  logic [6:0]       level;
  logic             full, push, drop, pop, load;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q, overflow_q;

  // Bit 6 of each pointer is the wrap flag, so the 7-bit difference spans 0..64.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == 7'd64);
  assign push  = bus.wr_en && !full && !bus.flush;
  assign drop  = bus.wr_en &&  full && !bus.flush;
  assign pop   = rd_valid_q && bus.rd_ready;
  assign load  = (!rd_valid_q || pop) && (level != 7'd0);

  // NOTE: RAM cells carry no reset; pointers alone define which cells hold data,
  // and a reset term here would stop the array mapping onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[5:0]] <= bus.wr_data;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, which gives the required no-bypass read-during-write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      // rd_data is intentionally left holding its last value.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 7'd1;
      if (drop) overflow_q <= 1'b1;
      if (load) begin
        rd_data_q  <= mem[rd_ptr[5:0]];
        rd_ptr     <= rd_ptr + 7'd1;
        rd_valid_q <= 1'b1;
      end else if (pop) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.full     = full;
  assign bus.level    = level;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fifo64_dpram.sv
// Randomized scoreboard bench for fifo64_dpram: a queue-based reference model
// predicts accepted words and occupancy; a monitor compares every DUT output.
module tb_fifo64_dpram;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fifo64_dpram_if #(.WIDTH(8)) bus ();

  fifo64_dpram #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: exp_q holds every word the FIFO owns, head = output register.
  logic [7:0] exp_q[$];
  int         m_ram  = 0;
  bit         m_out  = 1'b0;
  bit         m_ovf  = 1'b0;
  int         n_pops = 0;
  logic [7:0] held;
  bit         hold_chk = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    bit pop_e, acc, ld;
    if (!reset_n) begin
      exp_q.delete();
      m_ram    <= 0;
      m_out    <= 1'b0;
      m_ovf    <= 1'b0;
      hold_chk <= 1'b0;
    end else if (bus.flush) begin
      exp_q.delete();
      m_ram    <= 0;
      m_out    <= 1'b0;
      m_ovf    <= 1'b0;
      hold_chk <= 1'b0;
    end else begin
      pop_e = m_out && bus.rd_ready;
      acc   = bus.wr_en && (m_ram < 64);
      ld    = (!m_out || pop_e) && (m_ram > 0);
      if (pop_e) begin
        n_pops++;
        if (exp_q.size() == 0) check("pop_with_empty_scoreboard", 1, 0);
        else check("pop_data", bus.rd_data, exp_q.pop_front());
      end
      if (bus.wr_en && m_ram == 64) m_ovf <= 1'b1;
      if (acc) exp_q.push_back(bus.wr_data);
      m_ram    <= m_ram + int'(acc) - int'(ld);
      m_out    <= ld ? 1'b1 : (pop_e ? 1'b0 : m_out);
      held     <= bus.rd_data;
      hold_chk <= bus.rd_valid && !bus.rd_ready;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("level",    bus.level, m_ram);
      check("full",     bus.full, m_ram == 64);
      check("rd_valid", bus.rd_valid, m_out);
      check("overflow", bus.overflow, m_ovf);
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) check("head_present", 0, 1);
        else check("head_data", bus.rd_data, exp_q[0]);
      end
      if (hold_chk) begin
        check("stall_valid_held", bus.rd_valid, 1);
        check("stall_data_held", bus.rd_data, held);
      end
    end
  end

  // Apply inputs, then advance to just after the next rising edge.
  task automatic step(input bit we, input logic [7:0] d, input bit rr, input bit fl);
    bus.wr_en    = we;
    bus.wr_data  = d;
    bus.rd_ready = rr;
    bus.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.wr_en    = 1'b0;
    bus.rd_ready = 1'b1;
    bus.flush    = 1'b0;
    while ((bus.rd_valid || bus.level != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_drain_bounded"}, n < 200, 1);
    check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    int max_level;
    reset_n      = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data",  bus.rd_data, 0);
    check("rst_full",     bus.full, 0);
    check("rst_level",    bus.level, 0);
    check("rst_overflow", bus.overflow, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: push at edge 1, word at the output after edge 2.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("lat_edge1_valid", bus.rd_valid, 0);
    check("lat_edge1_level", bus.level, 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("lat_edge2_valid", bus.rd_valid, 1);
    check("lat_edge2_data",  bus.rd_data, 8'hA5);
    check("lat_edge2_level", bus.level, 0);
    drain("lat");

    // Fill to 65 words, then overflow.
    for (int i = 0; i <= 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_head",     bus.rd_data, 8'h00);
    check("fill_level",    bus.level, 64);
    check("fill_full",     bus.full, 1);
    check("fill_overflow", bus.overflow, 0);
    step(1'b1, 8'h41, 1'b0, 1'b0);
    check("ovf_set",   bus.overflow, 1);
    check("ovf_level", bus.level, 64);
    pops0 = n_pops;
    drain("fill");
    check("fill_pop_count", n_pops - pops0, 65);
    check("fill_end_valid", bus.rd_valid, 0);
    check("fill_end_full",  bus.full, 0);
    check("fill_end_ovf",   bus.overflow, 1);

    // Streaming across three pointer wraps.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    max_level = 0;
    pops0 = n_pops;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 8'(i + 7), 1'b1, 1'b0);
      if (int'(bus.level) > max_level) max_level = int'(bus.level);
    end
    check("stream_max_level_le1", max_level <= 1, 1);
    drain("stream");
    check("stream_pop_count", n_pops - pops0, 200);

    // Consumer stall with random traffic.
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    drain("stall");

    // Push and pop together at full: push dropped, level 63.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush_clears_ovf", bus.overflow, 0);
    for (int i = 0; i <= 64; i++) step(1'b1, 8'(i + 8'h80), 1'b0, 1'b0);
    check("sim_pre_level", bus.level, 64);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check("sim_level", bus.level, 63);
    check("sim_overflow", bus.overflow, 1);
    check("sim_valid", bus.rd_valid, 1);

    // Flush with concurrent push at level 30.
    for (int i = 0; i < 33; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_flush_level", bus.level, 30);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    check("flush_level",    bus.level, 0);
    check("flush_valid",    bus.rd_valid, 0);
    check("flush_overflow", bus.overflow, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("flush_push_ignored_level", bus.level, 0);
    check("flush_push_ignored_valid", bus.rd_valid, 0);

    // Asynchronous reset between edges.
    for (int i = 0; i <= 64; i++) step(1'b1, 8'(i + 3), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("pre_rst_overflow", bus.overflow, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid",    bus.rd_valid, 0);
    check("arst_data",     bus.rd_data, 0);
    check("arst_level",    bus.level, 0);
    check("arst_full",     bus.full, 0);
    check("arst_overflow", bus.overflow, 0);
    bus.wr_en = 1'b0;
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_data", bus.rd_data, 8'h3C);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
